// File: rtl/debug_reg_dump_if.sv
// Dump stream port of the debug register readout engine.
// The engine drives the word; the consumer answers with ready.
interface debug_reg_dump_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W:0]   dump_index;
    logic [DATA_W-1:0] dump_data;
    logic              dump_last;

    modport master (
        output dump_valid,
        output dump_index,
        output dump_data,
        output dump_last,
        input  dump_ready
    );

    modport slave (
        input  dump_valid,
        input  dump_index,
        input  dump_data,
        input  dump_last,
        output dump_ready
    );
endinterface

// File: rtl/debug_reg_dump.sv
// Debug readout engine: on a cycle-count trigger it stalls the core,
// drains, then streams every register and the captured PC.
module debug_reg_dump #(
    parameter int NUM_REGS     = 32,
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       trigger_cycle,
    input  logic              clear,
    input  logic [DATA_W-1:0] pc_in,
    output logic [ADDR_W-1:0] rf_rd_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic              stall_req,
    output logic              done,
    debug_reg_dump_if.master  dump
);

    localparam int IDX_W = ADDR_W + 1;
    localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_REG = IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W-1:0] PC_IDX   = IDX_W'(NUM_REGS);
    localparam logic [DRN_W-1:0] DRN_INIT = DRN_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_SEND,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic [31:0]       r_cycle_cnt;
    logic [DATA_W-1:0] r_pc_snap;
    logic [DATA_W-1:0] w_pc_snap_nx;
    logic [DRN_W-1:0]  r_drain;
    logic [DRN_W-1:0]  w_drain_nx;
    logic              r_stall;
    logic              w_stall_nx;
    logic              r_valid;
    logic              w_valid_nx;
    logic              r_last;
    logic              w_last_nx;
    logic              r_done;
    logic              w_done_nx;
    logic [IDX_W-1:0]  r_index;
    logic [IDX_W-1:0]  w_index_nx;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] w_data_nx;
    logic              r_fired;
    logic              w_fired_nx;
    logic [31:0]       r_fired_val;
    logic [31:0]       w_fired_val_nx;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_hs;
    logic              w_trig_hit;

    assign w_hs = r_valid && dump.dump_ready;

    // The fired-value guard only matters once the counter has saturated.
    assign w_trig_hit = (trigger_cycle != 32'd0)
                     && (r_cycle_cnt == trigger_cycle)
                     && !(r_fired && (r_fired_val == trigger_cycle));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt <= 32'd0;
        end else if (r_cycle_cnt != 32'hFFFF_FFFF) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pc_snap   <= '0;
            r_drain     <= '0;
            r_stall     <= 1'b0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_done      <= 1'b0;
            r_index     <= '0;
            r_data      <= '0;
            r_fired     <= 1'b0;
            r_fired_val <= 32'd0;
        end else begin
            r_state     <= w_state_nx;
            r_pc_snap   <= w_pc_snap_nx;
            r_drain     <= w_drain_nx;
            r_stall     <= w_stall_nx;
            r_valid     <= w_valid_nx;
            r_last      <= w_last_nx;
            r_done      <= w_done_nx;
            r_index     <= w_index_nx;
            r_data      <= w_data_nx;
            r_fired     <= w_fired_nx;
            r_fired_val <= w_fired_val_nx;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_pc_snap_nx   = r_pc_snap;
        w_drain_nx     = r_drain;
        w_stall_nx     = r_stall;
        w_valid_nx     = r_valid;
        w_last_nx      = r_last;
        w_done_nx      = r_done;
        w_index_nx     = r_index;
        w_data_nx      = r_data;
        w_fired_nx     = r_fired;
        w_fired_val_nx = r_fired_val;
        w_rd_addr      = '0;

        unique case (r_state)
            S_IDLE: begin
                if (w_trig_hit) begin
                    w_state_nx     = S_DRAIN;
                    w_stall_nx     = 1'b1;
                    w_pc_snap_nx   = pc_in;
                    w_drain_nx     = DRN_INIT;
                    w_fired_nx     = 1'b1;
                    w_fired_val_nx = trigger_cycle;
                end
            end
            S_DRAIN: begin
                if (r_drain == '0) begin
                    w_rd_addr  = '0;
                    w_state_nx = S_SEND;
                    w_valid_nx = 1'b1;
                    w_index_nx = '0;
                    w_data_nx  = rf_rd_data;
                end else begin
                    w_drain_nx = r_drain - 1'b1;
                end
            end
            S_SEND: begin
                if (w_hs) begin
                    if (r_last) begin
                        w_state_nx = S_DONE;
                        w_valid_nx = 1'b0;
                        w_last_nx  = 1'b0;
                        w_done_nx  = 1'b1;
                    end else if (r_index == LAST_REG) begin
                        w_index_nx = PC_IDX;
                        w_data_nx  = r_pc_snap;
                        w_last_nx  = 1'b1;
                    end else begin
                        // Address the next register so it loads at this edge.
                        w_rd_addr  = r_index[ADDR_W-1:0] + 1'b1;
                        w_index_nx = r_index + 1'b1;
                        w_data_nx  = rf_rd_data;
                    end
                end
            end
            S_DONE: begin
                w_state_nx = S_DONE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        // Abort wins over any handshake or trigger in the same cycle.
        if (clear) begin
            w_state_nx = S_IDLE;
            w_stall_nx = 1'b0;
            w_valid_nx = 1'b0;
            w_last_nx  = 1'b0;
            w_done_nx  = 1'b0;
            w_rd_addr  = '0;
        end
    end

    assign rf_rd_addr      = w_rd_addr;
    assign stall_req       = r_stall;
    assign done            = r_done;
    assign dump.dump_valid = r_valid;
    assign dump.dump_index = r_index;
    assign dump.dump_data  = r_data;
    assign dump.dump_last  = r_last;

endmodule

// File: tb/tb_debug_reg_dump.sv
// Randomized scoreboard bench for debug_reg_dump: stimulus queues the
// expected word stream, a monitor pops and compares each presented word.
module tb_debug_reg_dump;

    localparam int NR = 32;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DC = 4;

    typedef struct {
        logic [AW:0]   idx;
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   trigger_cycle;
    logic          clear;
    logic [31:0]   pc_base;
    logic [31:0]   pc_in;
    logic [AW-1:0] rf_rd_addr;
    logic [DW-1:0] rf_rd_data;
    logic          stall_req;
    logic          done;
    logic [DW-1:0] rf [NR];
    logic [31:0]   tb_cnt;

    logic [1:0]    rf2_addr;
    logic [31:0]   rf2_data;
    logic          stall2;
    logic          done2;

    int    n_cmp = 0;
    int    n_fail = 0;
    word_t exp_q[$];
    int    start_q[$];
    bit    u2_fin = 0;

    always #5 clk = ~clk;

    debug_reg_dump_if #(.ADDR_W(AW), .DATA_W(DW)) dif ();
    debug_reg_dump_if #(.ADDR_W(2), .DATA_W(32)) dif2 ();

    debug_reg_dump #(
        .NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW), .DRAIN_CYCLES(DC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .trigger_cycle(trigger_cycle),
        .clear(clear),
        .pc_in(pc_in),
        .rf_rd_addr(rf_rd_addr),
        .rf_rd_data(rf_rd_data),
        .stall_req(stall_req),
        .done(done),
        .dump(dif)
    );

    debug_reg_dump #(
        .NUM_REGS(4), .DATA_W(32), .ADDR_W(2), .DRAIN_CYCLES(1)
    ) dut2 (
        .clk(clk),
        .rst_n(rst_n),
        .trigger_cycle(32'd5),
        .clear(1'b0),
        .pc_in(32'hABCD_0123),
        .rf_rd_addr(rf2_addr),
        .rf_rd_data(rf2_data),
        .stall_req(stall2),
        .done(done2),
        .dump(dif2)
    );

    assign rf_rd_data      = rf[rf_rd_addr];
    assign pc_in           = pc_base + (tb_cnt << 2);
    assign rf2_data        = 32'(rf2_addr) * 32'd7 + 32'd3;
    assign dif2.dump_ready = 1'b1;

    // Reference cycle counter: counts edges since reset, saturating.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cnt <= 32'd0;
        else if (tb_cnt != 32'hFFFF_FFFF) tb_cnt <= tb_cnt + 32'd1;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented word is checked against the queue head.
    initial begin
        bit    prev_valid;
        bit    want_done;
        bit    want_next;
        word_t w;
        prev_valid = 0;
        want_done  = 0;
        want_next  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 0;
                want_done  = 0;
                want_next  = 0;
            end else begin
                if (want_done) begin
                    chk("done_after_last", {dif.dump_valid, done}, 2'b01);
                    want_done = 0;
                end
                if (want_next) begin
                    chk("back_to_back_valid", dif.dump_valid, 1);
                    want_next = 0;
                end
                if (dif.dump_valid && !prev_valid) begin
                    if (start_q.size() == 0) chk("unexpected_start", 1, 0);
                    else chk("first_valid_cycle", tb_cnt, start_q.pop_front());
                end
                if (dif.dump_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", 1, 0);
                    end else begin
                        chk("word_index", dif.dump_index, exp_q[0].idx);
                        chk("word_data", dif.dump_data, exp_q[0].data);
                        chk("word_last", dif.dump_last, exp_q[0].last);
                        if (dif.dump_ready && !clear) begin
                            w = exp_q.pop_front();
                            if (w.last) want_done = 1;
                            else want_next = 1;
                        end
                    end
                end
                prev_valid = dif.dump_valid;
            end
        end
    end

    // Small configuration: 4 registers, 1 drain cycle, trigger at 5.
    initial begin
        int w2;
        bit seen_done2;
        w2 = 0;
        seen_done2 = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rst_n && dif2.dump_valid) begin
                chk("u2_word_cycle", tb_cnt, 7 + w2);
                chk("u2_index", dif2.dump_index, w2);
                chk("u2_data", dif2.dump_data,
                    (w2 < 4) ? 32'(w2 * 7 + 3) : 32'hABCD_0123);
                chk("u2_last", dif2.dump_last, (w2 == 4));
                w2++;
            end
            if (rst_n && done2 && !seen_done2) begin
                seen_done2 = 1;
                chk("u2_done_cycle", tb_cnt, 12);
            end
        end
        chk("u2_word_count", w2, 5);
        chk("u2_done_seen", seen_done2, 1);
        u2_fin = 1;
    end

    // mode: 0 ready high, 1 ready pattern 1,0,0,1, 2 random ready.
    // stop_at >= 0 aborts with clear while that index is presented.
    task automatic do_dump(input logic [31:0] trig, input int mode,
                           input int stop_at);
        int    n;
        int    c;
        word_t w;
        n = (stop_at < 0) ? NR + 1 : stop_at + 1;
        for (int k = 0; k < n; k++) begin
            w.idx  = (AW + 1)'(k);
            w.data = (k < NR) ? rf[k] : pc_base + (trig << 2);
            w.last = (k == NR);
            exp_q.push_back(w);
        end
        start_q.push_back(int'(trig) + 1 + DC);
        dif.dump_ready = 1'b1;
        trigger_cycle  = trig;
        c = 0;
        @(negedge clk);
        while (tb_cnt != trig && c < 3000) begin
            @(negedge clk);
            c++;
        end
        chk("reach_trigger", tb_cnt, trig);
        chk("stall_before_E", stall_req, 0);
        @(negedge clk);
        chk("stall_at_E", stall_req, 1);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (done) break;
            if (stop_at >= 0 && dif.dump_valid && dif.dump_index == stop_at) begin
                dif.dump_ready = 1'b1;
                clear = 1'b1;
                @(posedge clk);
                #1;
                clear = 1'b0;
                chk("abort_idle", {stall_req, dif.dump_valid, dif.dump_last, done}, 0);
                chk("abort_pending_word", exp_q.size(), 1);
                exp_q.delete();
                repeat (3) begin
                    @(negedge clk);
                    chk("abort_stays_idle", {stall_req, dif.dump_valid}, 0);
                end
                return;
            end
            case (mode)
                1: dif.dump_ready = (i % 4 == 0) || (i % 4 == 3);
                2: dif.dump_ready = ($urandom_range(0, 3) != 0);
                default: dif.dump_ready = 1'b1;
            endcase
        end
        chk("done_reached", done, 1);
        dif.dump_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("done_held", {done, stall_req, dif.dump_valid}, 3'b110);
        @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk("clear_idle", {stall_req, dif.dump_valid, dif.dump_last, done}, 0);
        chk("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic rand_rf();
        for (int i = 0; i < NR; i++) rf[i] = $urandom;
        pc_base = $urandom;
    endtask

    initial begin
        logic [31:0] trig;
        rand_rf();
        rf[0] = 32'd5;
        rf[1] = 32'd15;
        rf[2] = 32'd0;
        rf[3] = 32'd15;
        pc_base = 32'd56;
        trigger_cycle  = 32'd11;
        clear          = 1'b0;
        dif.dump_ready = 1'b1;
        #2;
        chk("reset_outputs",
            {stall_req, dif.dump_valid, dif.dump_last, done,
             dif.dump_index, rf_rd_addr}, 0);
        chk("reset_data", dif.dump_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_dump(32'd11, 0, -1);
        do_dump(tb_cnt + 8, 1, -1);

        trigger_cycle = 32'd0;
        repeat (100) begin
            @(negedge clk);
            chk("trigger0_quiet", {stall_req, dif.dump_valid, done}, 0);
        end

        trigger_cycle = tb_cnt - 5;
        repeat (30) begin
            @(negedge clk);
            chk("past_trigger_quiet", {stall_req, dif.dump_valid, done}, 0);
        end

        rand_rf();
        do_dump(tb_cnt + 6, 0, 7);
        do_dump(tb_cnt + 5, 0, -1);

        for (int r = 0; r < 3; r++) begin
            rand_rf();
            do_dump(tb_cnt + $urandom_range(3, 20), 2, -1);
        end

        rand_rf();
        trig = tb_cnt + 10;
        trigger_cycle = trig;
        for (int c = 0; c < 100 && tb_cnt != trig + 2; c++) @(negedge clk);
        chk("in_drain_stall", stall_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            {stall_req, dif.dump_valid, dif.dump_last, done,
             dif.dump_index, rf_rd_addr}, 0);
        chk("async_reset_data", dif.dump_data, 0);
        chk("async_reset_cnt", dut.r_cycle_cnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_dump(trig, 2, -1);

        wait (u2_fin);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cmp=%0d fail=%0d",
                 n_cmp, n_fail);
        $fatal(1);
    end

endmodule
